alu_sequencer: RTL and testbench

Multicycle instruction sequencer for the 8-bit CPU. It accepts one-byte instructions, or two bytes for LDI, over a valid/ready handshake and holds four 8-bit general registers R0-R3. It drives the shared combinational ALU, registers its result, and writes back to the destination register while maintaining a Z/N/C/V flag register.

---
 rtl/alu_sequencer_pkg.sv | 34 +++
 rtl/alu_sequencer_if.sv | 9 +
 rtl/alu_seq_regfile.sv | 36 +++
 rtl/alu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode, state and flag definitions for the alu_sequencer block.
// The optional saturation feature is selected with the ALU_SEQ_SATURATE_EN macro.
package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MOV = 3'b101,
        OP_LDI = 3'b110,
        OP_NOP = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_IMM   = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WB    = 2'b11
    } state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Signed overflow of a - b, derived from operand and result sign bits.
    function automatic logic sub_overflow(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] r);
        return (a[7] != b[7]) && (r[7] != a[7]);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction byte valid/ready channel into the sequencer.
interface alu_sequencer_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_data;

    modport master (output instr_valid, output instr_data, input instr_ready);
    modport slave  (input instr_valid, input instr_data, output instr_ready);
endinterface

// File: rtl/alu_seq_regfile.sv
// Four 8-bit general registers: two async operand reads, an async debug read,
// one synchronous write port, asynchronous reset to REG_INIT.
module alu_seq_regfile #(
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [1:0] rd_addr_i,
    input  logic [1:0] rs_addr_i,
    input  logic [1:0] dbg_sel_i,
    output logic [7:0] rd_data_o,
    output logic [7:0] rs_data_o,
    output logic [7:0] dbg_data_o
);

    logic [7:0] regs_q [4];

    // Register storage with single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= REG_INIT;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_data_o  = regs_q[rd_addr_i];
    assign rs_data_o  = regs_q[rs_addr_i];
    assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle FETCH/IMM/EXEC/WB sequencer driving an external ALU.
// Define ALU_SEQ_SATURATE_EN to saturate ADD/SUB results on signed overflow.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter logic [7:0] REG_INIT   = 8'h00,
    parameter int         DONE_PULSE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_sequencer_if.slave        instr_if,
    output logic [2:0]            alu_op,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    input  logic [7:0]            alu_result,
    input  logic                  alu_cout,
    input  logic                  alu_overflow,
    output logic                  done,
    output logic [3:0]            flags,
    input  logic [1:0]            dbg_sel,
    output logic [7:0]            dbg_data
);

    state_e     state_q;
    logic [7:1] instr_q;
    logic [7:0] res_q;
    logic [1:0] cv_q;
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       done_q;

    opcode_e    op_s;
    opcode_e    in_op_s;
    logic [7:0] rd_data_s;
    logic [7:0] rs_data_s;
    logic [7:0] raw_res_s;
    logic [7:0] exec_res_s;
    logic       exec_c_s;
    logic       exec_v_s;
    logic       wb_en_s;
    logic       wb_z_s;
    logic       wb_n_s;

    assign op_s    = opcode_e'(instr_q[7:5]);
    assign in_op_s = opcode_e'(instr_if.instr_data[7:5]);
    assign wb_en_s = (state_q == ST_WB) && (op_s != OP_NOP);
    assign wb_z_s  = (res_q == 8'h00);
    assign wb_n_s  = res_q[7];

    alu_seq_regfile #(.REG_INIT(REG_INIT)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (wb_en_s),
        .waddr_i    (instr_q[4:3]),
        .wdata_i    (res_q),
        .rd_addr_i  (instr_q[4:3]),
        .rs_addr_i  (instr_q[2:1]),
        .dbg_sel_i  (dbg_sel),
        .rd_data_o  (rd_data_s),
        .rs_data_o  (rs_data_s),
        .dbg_data_o (dbg_data)
    );

    // Raw execute result and carry/overflow for the latched opcode.
    always_comb begin
        raw_res_s = alu_result;
        exec_c_s  = 1'b0;
        exec_v_s  = 1'b0;
        case (op_s)
            OP_ADD: begin
                exec_c_s = alu_cout;
                exec_v_s = alu_overflow;
            end
            OP_SUB: begin
                exec_c_s = alu_cout;
                exec_v_s = sub_overflow(rd_data_s, rs_data_s, alu_result);
            end
            OP_AND, OP_OR, OP_XOR: begin
                exec_c_s = 1'b0;
                exec_v_s = 1'b0;
            end
            OP_MOV:  raw_res_s = rs_data_s;
            default: raw_res_s = alu_result;
        endcase
    end

    // Optional clamp of overflowing ADD/SUB results; C and V stay as computed.
    always_comb begin
`ifdef ALU_SEQ_SATURATE_EN
        if (((op_s == OP_ADD) || (op_s == OP_SUB)) && exec_v_s) begin
            exec_res_s = rd_data_s[7] ? 8'h80 : 8'h7F;
        end else begin
            exec_res_s = raw_res_s;
        end
`else
        exec_res_s = raw_res_s;
`endif
    end

    // Writeback flag update: MOV/LDI keep C,V; NOP keeps everything.
    always_comb begin
        flags_d = flags_q;
        case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                flags_d = {wb_z_s, wb_n_s, cv_q};
            end
            OP_MOV, OP_LDI: begin
                flags_d[FLAG_Z] = wb_z_s;
                flags_d[FLAG_N] = wb_n_s;
            end
            default: flags_d = flags_q;
        endcase
    end

    // Sequencer FSM with registered result, flags and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            instr_q <= 7'h00;
            res_q   <= 8'h00;
            cv_q    <= 2'b00;
            flags_q <= 4'b0000;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (instr_if.instr_valid) begin
                        instr_q <= instr_if.instr_data[7:1];
                        done_q  <= (in_op_s == OP_NOP);
                        case (in_op_s)
                            OP_LDI:  state_q <= ST_IMM;
                            OP_NOP:  state_q <= ST_WB;
                            default: state_q <= ST_EXEC;
                        endcase
                    end
                end
                ST_IMM: begin
                    if (instr_if.instr_valid) begin
                        res_q   <= instr_if.instr_data;
                        done_q  <= 1'b1;
                        state_q <= ST_WB;
                    end
                end
                ST_EXEC: begin
                    res_q   <= exec_res_s;
                    cv_q    <= {exec_c_s, exec_v_s};
                    done_q  <= 1'b1;
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    flags_q <= flags_d;
                    done_q  <= (DONE_PULSE == 0);
                    state_q <= ST_FETCH;
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign instr_if.instr_ready = (state_q == ST_FETCH) || (state_q == ST_IMM);
    assign alu_op = instr_q[7:5];
    assign alu_a  = rd_data_s;
    assign alu_b  = rs_data_s;
    assign done   = done_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU model.
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic       alu_overflow;
    logic       done;
    logic [3:0] flags;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int compared;
    int mismatched;

    alu_sequencer_if ifc ();

    alu_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_if     (ifc),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .done         (done),
        .flags        (flags),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; overflow and MOV result are deliberately bogus where unused.
    logic [8:0] sum_s;
    logic [7:0] diff_s;
    always_comb begin
        sum_s        = {1'b0, alu_a} + {1'b0, alu_b};
        diff_s       = alu_a - alu_b;
        alu_result   = 8'hA5;
        alu_cout     = 1'b0;
        alu_overflow = 1'b1;
        case (alu_op)
            3'b000: begin
                alu_result   = sum_s[7:0];
                alu_cout     = sum_s[8];
                alu_overflow = (alu_a[7] == alu_b[7]) && (sum_s[7] != alu_a[7]);
            end
            3'b001: begin
                alu_result   = diff_s;
                alu_cout     = (alu_a < alu_b);
                alu_overflow = !((alu_a[7] != alu_b[7]) && (diff_s[7] != alu_a[7]));
            end
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: alu_result = 8'hA5;
        endcase
    end

    function automatic logic [7:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs);
        return {op, rd, rs, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ifc.instr_valid = 1'b1;
        ifc.instr_data  = b;
        while (ifc.instr_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            compared++; mismatched++;
            $display("FAIL handshake_timeout ready=%b required=1", ifc.instr_ready);
        end
        @(posedge clk); #1;
        ifc.instr_valid = 1'b0;
        ifc.instr_data  = 8'h00;
    endtask

    task automatic do_alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
        send_byte(enc(op, rd, rs));
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic do_ldi(input logic [1:0] rd, input logic [7:0] imm);
        send_byte(enc(3'b110, rd, 2'd0));
        send_byte(imm);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.instr_valid = 1'b0;
        ifc.instr_data  = 8'h00;
        dbg_sel = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (ifc.instr_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got=%b exp=1", ifc.instr_ready); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got=%b exp=0", done); end
        compared++;
        if (flags !== 4'b0000) begin mismatched++; $display("FAIL reset_flags got=%b exp=0000", flags); end
        compared++;
        if (alu_op !== 3'b000 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
            mismatched++; $display("FAIL reset_alu got=%b/%h/%h exp=000/00/00", alu_op, alu_a, alu_b);
        end
        compared++;
        if (dbg_data !== 8'h00) begin mismatched++; $display("FAIL reset_r2 got=%h exp=00", dbg_data); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ldi_reset();
        send_byte(enc(3'b110, 2'd1, 2'd0));
        compared++;
        if (alu_op !== 3'b110) begin mismatched++; $display("FAIL imm_alu_op got=%b exp=110", alu_op); end
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        compared++;
        if (alu_op !== 3'b000 || done !== 1'b0) begin
            mismatched++; $display("FAIL async_reset got=%b/%b exp=000/0", alu_op, done);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        dbg_sel = 2'd1; #1;
        compared++;
        if (dbg_data !== 8'h00) begin mismatched++; $display("FAIL reset_no_wb got=%h exp=00", dbg_data); end
        send_byte(enc(3'b110, 2'd1, 2'd0));
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL ldi_done_early got=%b exp=0", done); end
        send_byte(8'h7F);
        compared++;
        if (done !== 1'b1) begin mismatched++; $display("FAIL ldi_done_wb got=%b exp=1", done); end
        @(posedge clk); #1;
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL ldi_done_pulse got=%b exp=0", done); end
        compared++;
        if (dbg_data !== 8'h7F) begin mismatched++; $display("FAIL ldi_r1 got=%h exp=7f", dbg_data); end
        compared++;
        if (flags !== 4'b0000) begin mismatched++; $display("FAIL ldi_flags got=%b exp=0000", flags); end
    endtask

    task automatic test_add_overflow();
        logic [7:0] exp_r;
        logic [3:0] exp_f;
`ifdef ALU_SEQ_SATURATE_EN
        exp_r = 8'h7F; exp_f = 4'b0001;
`else
        exp_r = 8'h80; exp_f = 4'b0101;
`endif
        do_ldi(2'd0, 8'h7F);
        do_ldi(2'd1, 8'h01);
        do_alu(3'b000, 2'd0, 2'd1);
        dbg_sel = 2'd0; #1;
        compared++;
        if (dbg_data !== exp_r) begin mismatched++; $display("FAIL add_ovf_r0 got=%h exp=%h", dbg_data, exp_r); end
        compared++;
        if (flags !== exp_f) begin mismatched++; $display("FAIL add_ovf_flags got=%b exp=%b", flags, exp_f); end
    endtask

    task automatic test_sub();
        logic [7:0] exp_r;
        logic [3:0] exp_f;
`ifdef ALU_SEQ_SATURATE_EN
        exp_r = 8'h80; exp_f = 4'b0101;
`else
        exp_r = 8'h7F; exp_f = 4'b0001;
`endif
        do_ldi(2'd2, 8'h80);
        do_ldi(2'd3, 8'h01);
        do_alu(3'b001, 2'd2, 2'd3);
        dbg_sel = 2'd2; #1;
        compared++;
        if (dbg_data !== exp_r) begin mismatched++; $display("FAIL sub_ovf_r2 got=%h exp=%h", dbg_data, exp_r); end
        compared++;
        if (flags !== exp_f) begin mismatched++; $display("FAIL sub_ovf_flags got=%b exp=%b", flags, exp_f); end
        do_ldi(2'd0, 8'h05);
        do_ldi(2'd1, 8'h05);
        do_alu(3'b001, 2'd0, 2'd1);
        dbg_sel = 2'd0; #1;
        compared++;
        if (dbg_data !== 8'h00 || flags !== 4'b1000) begin
            mismatched++; $display("FAIL sub_zero got=%h/%b exp=00/1000", dbg_data, flags);
        end
        do_ldi(2'd0, 8'h01);
        do_ldi(2'd1, 8'h02);
        do_alu(3'b001, 2'd0, 2'd1);
        compared++;
        if (dbg_data !== 8'hFF || flags !== 4'b0110) begin
            mismatched++; $display("FAIL sub_borrow got=%h/%b exp=ff/0110", dbg_data, flags);
        end
    endtask

    task automatic test_logic_mov();
        logic [7:0] exp_r;
        logic [3:0] exp_f;
`ifdef ALU_SEQ_SATURATE_EN
        exp_r = 8'h80; exp_f = 4'b0111;
`else
        exp_r = 8'h00; exp_f = 4'b1011;
`endif
        do_ldi(2'd2, 8'h80);
        do_ldi(2'd3, 8'h80);
        do_alu(3'b000, 2'd2, 2'd3);
        dbg_sel = 2'd2; #1;
        compared++;
        if (dbg_data !== exp_r || flags !== exp_f) begin
            mismatched++; $display("FAIL add_cv got=%h/%b exp=%h/%b", dbg_data, flags, exp_r, exp_f);
        end
        do_alu(3'b100, 2'd1, 2'd1);
        dbg_sel = 2'd1; #1;
        compared++;
        if (dbg_data !== 8'h00 || flags !== 4'b1000) begin
            mismatched++; $display("FAIL xor_alias got=%h/%b exp=00/1000", dbg_data, flags);
        end
        do_ldi(2'd0, 8'hFF);
        do_ldi(2'd1, 8'h01);
        do_alu(3'b000, 2'd0, 2'd1);
        dbg_sel = 2'd0; #1;
        compared++;
        if (dbg_data !== 8'h00 || flags !== 4'b1010) begin
            mismatched++; $display("FAIL add_carry got=%h/%b exp=00/1010", dbg_data, flags);
        end
        do_alu(3'b101, 2'd2, 2'd3);
        dbg_sel = 2'd2; #1;
        compared++;
        if (dbg_data !== 8'h80 || flags !== 4'b0110) begin
            mismatched++; $display("FAIL mov_flags got=%h/%b exp=80/0110", dbg_data, flags);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream [4];
        int idx;
        int cyc;
        int last;
        logic rdy;
        stream[0] = enc(3'b000, 2'd1, 2'd1);
        stream[1] = enc(3'b000, 2'd1, 2'd1);
        stream[2] = enc(3'b000, 2'd1, 2'd1);
        stream[3] = {3'b011, 2'd0, 2'd1, 1'b1};
        idx = 0; cyc = 0; last = 0;
        ifc.instr_valid = 1'b1;
        ifc.instr_data  = stream[0];
        while (idx < 4 && cyc < 40) begin
            rdy = ifc.instr_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy === 1'b1) begin
                if (idx > 0) begin
                    compared++;
                    if (cyc - last != 3) begin
                        mismatched++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=3", idx, cyc - last);
                    end
                end
                last = cyc;
                idx++;
                if (idx < 4) ifc.instr_data = stream[idx];
            end
        end
        ifc.instr_valid = 1'b0;
        ifc.instr_data  = 8'h00;
        if (idx < 4) begin
            compared++; mismatched++;
            $display("FAIL b2b_timeout got=%0d exp=4 transfers", idx);
        end
        repeat (2) begin @(posedge clk); #1; end
        dbg_sel = 2'd1; #1;
        compared++;
        if (dbg_data !== 8'h08) begin mismatched++; $display("FAIL b2b_r1 got=%h exp=08", dbg_data); end
        dbg_sel = 2'd0; #1;
        compared++;
        if (dbg_data !== 8'h08 || flags !== 4'b0000) begin
            mismatched++; $display("FAIL b2b_or got=%h/%b exp=08/0000", dbg_data, flags);
        end
    endtask

    task automatic test_imm_stall();
        do_alu(3'b000, 2'd2, 2'd2);
        send_byte(enc(3'b110, 2'd3, 2'd0));
        repeat (5) begin @(posedge clk); #1; end
        dbg_sel = 2'd3; #1;
        compared++;
        if (ifc.instr_ready !== 1'b1 || done !== 1'b0 || dbg_data !== 8'h80) begin
            mismatched++;
            $display("FAIL imm_stall got=%b/%b/%h exp=1/0/80", ifc.instr_ready, done, dbg_data);
        end
        send_byte(8'h3C);
        compared++;
        if (done !== 1'b1) begin mismatched++; $display("FAIL imm_done got=%b exp=1", done); end
        @(posedge clk); #1;
        compared++;
        if (dbg_data !== 8'h3C || flags !== 4'b0011) begin
            mismatched++; $display("FAIL imm_wb got=%h/%b exp=3c/0011", dbg_data, flags);
        end
    endtask

    task automatic test_nop();
        dbg_sel = 2'd3;
        send_byte(8'hFC);
        compared++;
        if (done !== 1'b1) begin mismatched++; $display("FAIL nop_done got=%b exp=1", done); end
        @(posedge clk); #1;
        compared++;
        if (done !== 1'b0 || ifc.instr_ready !== 1'b1) begin
            mismatched++; $display("FAIL nop_end got=%b/%b exp=0/1", done, ifc.instr_ready);
        end
        compared++;
        if (dbg_data !== 8'h3C || flags !== 4'b0011) begin
            mismatched++; $display("FAIL nop_state got=%h/%b exp=3c/0011", dbg_data, flags);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_ldi_reset();
        test_add_overflow();
        test_sub();
        test_logic_mov();
        test_back_to_back();
        test_imm_stall();
        test_nop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
